// File: rtl/stopwatch_timer_core.sv
// min:sec:ms stopwatch/timer core: prescaled ms tick, edge-detected buttons,
// up (stopwatch) and down (timer) counting, lap capture, rollover and expiry.
module stopwatch_timer_core #(
    parameter int CLK_PER_MS  = 1,
    parameter int MIN_W       = 6,
    parameter int MAX_MINUTES = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    input  logic             load,
    input  logic             mode,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [9:0]       milliseconds,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec,
    output logic [9:0]       lap_ms,
    output logic             lap_valid,
    output logic             running,
    output logic             expired,
    output logic             rollover
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [MIN_W-1:0] MAX_M      = MIN_W'(MAX_MINUTES);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

    state_t           state_reg, state_next;
    logic             mode_q_reg, mode_q_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic [MIN_W-1:0] min_reg, min_next;
    logic [5:0]       sec_reg, sec_next;
    logic [9:0]       ms_reg, ms_next;
    logic [MIN_W-1:0] lap_min_reg, lap_min_next;
    logic [5:0]       lap_sec_reg, lap_sec_next;
    logic [9:0]       lap_ms_reg, lap_ms_next;
    logic             lap_valid_reg, lap_valid_next;
    logic             rollover_reg, rollover_next;
    logic             running_reg, expired_reg;
    logic             ss_q_reg, lap_q_reg;

    logic ss_edge, lap_edge, tick, time_zero;
    logic [MIN_W-1:0] up_min, dn_min;
    logic [5:0]       up_sec, dn_sec;
    logic [9:0]       up_ms, dn_ms;
    logic             up_wrap, dn_zero;

    assign ss_edge   = start_stop & ~ss_q_reg;
    assign lap_edge  = lap & ~lap_q_reg;
    assign tick      = (state_reg == RUNNING) && (presc_reg == PRESC_LAST);
    assign time_zero = (min_reg == '0) && (sec_reg == '0) && (ms_reg == '0);

    // Candidate next time for each direction; chosen only on a tick.
    always_comb begin
        up_min  = min_reg;
        up_sec  = sec_reg;
        up_ms   = ms_reg + 10'd1;
        up_wrap = 1'b0;
        if (ms_reg == 10'd999) begin
            up_ms = '0;
            if (sec_reg == 6'd59) begin
                up_sec = '0;
                if (min_reg == MAX_M) begin
                    up_min  = '0;
                    up_wrap = 1'b1;
                end else begin
                    up_min = min_reg + MIN_W'(1);
                end
            end else begin
                up_sec = sec_reg + 6'd1;
            end
        end

        dn_min = min_reg;
        dn_sec = sec_reg;
        dn_ms  = ms_reg - 10'd1;
        if (ms_reg == '0) begin
            dn_ms = 10'd999;
            if (sec_reg == '0) begin
                dn_sec = 6'd59;
                dn_min = min_reg - MIN_W'(1);
            end else begin
                dn_sec = sec_reg - 6'd1;
            end
        end
        dn_zero = (dn_min == '0) && (dn_sec == '0) && (dn_ms == '0);
    end

    always_comb begin
        state_next     = state_reg;
        mode_q_next    = mode_q_reg;
        presc_next     = presc_reg;
        min_next       = min_reg;
        sec_next       = sec_reg;
        ms_next        = ms_reg;
        lap_min_next   = lap_min_reg;
        lap_sec_next   = lap_sec_reg;
        lap_ms_next    = lap_ms_reg;
        lap_valid_next = 1'b0;
        rollover_next  = 1'b0;

        // Lap snapshots the pre-tick time and never blocks the count.
        if (lap_edge && (state_reg == RUNNING) && !clear) begin
            lap_min_next   = min_reg;
            lap_sec_next   = sec_reg;
            lap_ms_next    = ms_reg;
            lap_valid_next = 1'b1;
        end

        if (clear) begin
            min_next   = '0;
            sec_next   = '0;
            ms_next    = '0;
            presc_next = '0;
            state_next = IDLE;
        end else if (load && (state_reg != RUNNING)) begin
            min_next   = (load_min > MAX_M) ? MAX_M : load_min;
            sec_next   = (load_sec > 6'd59) ? 6'd59 : load_sec;
            ms_next    = '0;
            presc_next = '0;
            state_next = IDLE;
        end else if (ss_edge && (state_reg != EXPIRED)) begin
            case (state_reg)
                IDLE: begin
                    if (!(mode && time_zero)) begin
                        state_next  = RUNNING;
                        mode_q_next = mode;
                    end
                end
                PAUSED: begin
                    if (!(mode_q_reg && time_zero)) state_next = RUNNING;
                end
                RUNNING: state_next = PAUSED;
                default: state_next = state_reg;
            endcase
        end else if (state_reg == RUNNING) begin
            if (tick) begin
                presc_next = '0;
                if (mode_q_reg) begin
                    min_next = dn_min;
                    sec_next = dn_sec;
                    ms_next  = dn_ms;
                    if (dn_zero) state_next = EXPIRED;
                end else begin
                    min_next      = up_min;
                    sec_next      = up_sec;
                    ms_next       = up_ms;
                    rollover_next = up_wrap;
                end
            end else begin
                presc_next = presc_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            mode_q_reg    <= 1'b0;
            presc_reg     <= '0;
            min_reg       <= '0;
            sec_reg       <= '0;
            ms_reg        <= '0;
            lap_min_reg   <= '0;
            lap_sec_reg   <= '0;
            lap_ms_reg    <= '0;
            lap_valid_reg <= 1'b0;
            rollover_reg  <= 1'b0;
            running_reg   <= 1'b0;
            expired_reg   <= 1'b0;
            ss_q_reg      <= 1'b0;
            lap_q_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_q_reg    <= mode_q_next;
            presc_reg     <= presc_next;
            min_reg       <= min_next;
            sec_reg       <= sec_next;
            ms_reg        <= ms_next;
            lap_min_reg   <= lap_min_next;
            lap_sec_reg   <= lap_sec_next;
            lap_ms_reg    <= lap_ms_next;
            lap_valid_reg <= lap_valid_next;
            rollover_reg  <= rollover_next;
            running_reg   <= (state_next == RUNNING);
            expired_reg   <= (state_next == EXPIRED);
            ss_q_reg      <= start_stop;
            lap_q_reg     <= lap;
        end
    end

    assign minutes      = min_reg;
    assign seconds      = sec_reg;
    assign milliseconds = ms_reg;
    assign lap_min      = lap_min_reg;
    assign lap_sec      = lap_sec_reg;
    assign lap_ms       = lap_ms_reg;
    assign lap_valid    = lap_valid_reg;
    assign running      = running_reg;
    assign expired      = expired_reg;
    assign rollover     = rollover_reg;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: directed scenarios then random stimulus,
// checked every cycle against a total-milliseconds reference model.
module tb_stopwatch_timer_core;

    localparam int CPM   = 4;
    localparam int MIN_W = 6;
    localparam int MAXM  = 1;
    localparam int TOTAL = (MAXM + 1) * 60000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start_stop = 1'b0, lap = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0;
    logic [MIN_W-1:0] load_min = '0;
    logic [5:0]       load_sec = '0;
    logic [MIN_W-1:0] minutes, lap_min;
    logic [5:0]       seconds, lap_sec;
    logic [9:0]       milliseconds, lap_ms;
    logic             lap_valid, running, expired, rollover;

    int tests = 0;
    int failures = 0;

    // Reference model state: time as a single millisecond count.
    int t_ms, lap_t, m_presc;
    bit m_run, m_pause, m_exp, m_mode, m_ssq, m_lapq, m_lv, m_ro;

    stopwatch_timer_core #(.CLK_PER_MS(CPM), .MIN_W(MIN_W), .MAX_MINUTES(MAXM)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .load(load), .mode(mode), .load_min(load_min), .load_sec(load_sec),
        .minutes(minutes), .seconds(seconds), .milliseconds(milliseconds),
        .lap_min(lap_min), .lap_sec(lap_sec), .lap_ms(lap_ms), .lap_valid(lap_valid),
        .running(running), .expired(expired), .rollover(rollover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        t_ms = 0; lap_t = 0; m_presc = 0;
        m_run = 0; m_pause = 0; m_exp = 0; m_mode = 0;
        m_ssq = 0; m_lapq = 0; m_lv = 0; m_ro = 0;
    endtask

    task automatic model_update();
        bit ss, le, eff;
        int lm, ls;
        ss = start_stop && !m_ssq;
        le = lap && !m_lapq;
        m_lv = 0;
        m_ro = 0;
        if (le && m_run && !clear) begin
            lap_t = t_ms;
            m_lv = 1;
        end
        if (clear) begin
            t_ms = 0; m_presc = 0; m_run = 0; m_pause = 0; m_exp = 0;
        end else if (load && !m_run) begin
            lm = (int'(load_min) > MAXM) ? MAXM : int'(load_min);
            ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
            t_ms = lm * 60000 + ls * 1000;
            m_presc = 0; m_pause = 0; m_exp = 0;
        end else if (ss && !m_exp) begin
            if (m_run) begin
                m_run = 0; m_pause = 1;
            end else begin
                eff = m_pause ? m_mode : mode;
                if (!(eff && t_ms == 0)) begin
                    if (!m_pause) m_mode = mode;
                    m_run = 1; m_pause = 0;
                end
            end
        end else if (m_run) begin
            if (m_presc == CPM - 1) begin
                m_presc = 0;
                if (!m_mode) begin
                    t_ms++;
                    if (t_ms == TOTAL) begin t_ms = 0; m_ro = 1; end
                end else begin
                    t_ms--;
                    if (t_ms == 0) begin m_run = 0; m_exp = 1; end
                end
            end else begin
                m_presc++;
            end
        end
        m_ssq = start_stop;
        m_lapq = lap;
    endtask

    task automatic compare_all();
        chk("minutes", int'(minutes), t_ms / 60000);
        chk("seconds", int'(seconds), (t_ms / 1000) % 60);
        chk("milliseconds", int'(milliseconds), t_ms % 1000);
        chk("lap_min", int'(lap_min), lap_t / 60000);
        chk("lap_sec", int'(lap_sec), (lap_t / 1000) % 60);
        chk("lap_ms", int'(lap_ms), lap_t % 1000);
        chk("lap_valid", int'(lap_valid), int'(m_lv));
        chk("running", int'(running), int'(m_run));
        chk("expired", int'(expired), int'(m_exp));
        chk("rollover", int'(rollover), int'(m_ro));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_update();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; step(); start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic do_load(input int mn, input int sc);
        load_min = MIN_W'(mn); load_sec = 6'(sc);
        load = 1'b1; step(); load = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int expv);
        chk(tag, int'(minutes) * 60000 + int'(seconds) * 1000 + int'(milliseconds), expv);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_time"}, int'(minutes) + int'(seconds) + int'(milliseconds), 0);
        chk({tag, "_lap"}, int'(lap_min) + int'(lap_sec) + int'(lap_ms), 0);
        chk({tag, "_flags"}, int'({lap_valid, running, expired, rollover}), 0);
    endtask

    initial begin
        int n, lv_count;
        model_reset();
        steps(3);
        reset = 1'b0;
        steps(2);
        chk_all_zero("reset_state");
        $display("[TB] reset released");

        // Up count: start latency and first tick
        pulse_ss();
        chk("start_running", int'(running), 1);
        steps(CPM - 1);
        chk("pre_first_tick_ms", int'(milliseconds), 0);
        step();
        chk("first_tick_ms", int'(milliseconds), 1);
        steps(4000);
        chk_time("up_1001", 1001);
        $display("[TB] up count reached %0d:%0d:%0d", minutes, seconds, milliseconds);

        // Pause/resume
        do_clear();
        pulse_ss();
        steps(10 * CPM);
        chk_time("pause_point", 10);
        steps(1);
        pulse_ss();
        steps(50);
        chk("paused_running", int'(running), 0);
        chk_time("paused_hold", t_ms);
        chk("paused_model_time", t_ms, 10 + ((CPM == 1) ? 1 : 0));
        pulse_ss();
        steps(3 * CPM + 2);
        $display("[TB] resumed, now %0d ms", milliseconds);

        // Lap at 0:00:500, then held lap button
        do_clear();
        pulse_ss();
        n = 0;
        while (t_ms < 500 && n < 5000) begin step(); n++; end
        chk("lap_wait_bound", int'(n < 5000), 1);
        chk_time("lap_point", 500);
        lap = 1'b1; step();
        chk("lap_valid_hi", int'(lap_valid), 1);
        chk("lap_ms_500", int'(lap_ms), 500);
        lv_count = 0;
        for (int i = 0; i < 10; i++) begin step(); lv_count += int'(lap_valid); end
        lap = 1'b0;
        chk("lap_held_pulses", lv_count, 0);
        $display("[TB] lap captured %0d:%0d:%0d", lap_min, lap_sec, lap_ms);

        // Load ignored while running
        n = t_ms;
        do_load(1, 30);
        chk("load_ignored_min", int'(minutes), 0);
        chk("load_ignored_running", int'(running), 1);

        // Clear beats start_stop in the same cycle
        clear = 1'b1; start_stop = 1'b1; step(); clear = 1'b0; start_stop = 1'b0;
        chk_time("clear_ss_time", 0);
        chk("clear_ss_running", int'(running), 0);
        $display("[TB] clear with start_stop -> idle");

        // Down count from 0:02
        do_load(0, 2);
        mode = 1'b1;
        pulse_ss();
        mode = 1'b0;
        n = 0;
        while (!m_exp && n < 9000) begin step(); n++; end
        chk("down_wait_bound", int'(n < 9000), 1);
        chk("down_ticks_cycles", n, 2000 * CPM);
        chk_time("down_zero", 0);
        chk("down_expired", int'(expired), 1);
        chk("down_running", int'(running), 0);
        pulse_ss();
        steps(10);
        chk("expired_ignores_ss", int'(expired), 1);
        do_clear();
        chk("clear_expired", int'(expired), 0);
        $display("[TB] timer expired and cleared");

        // Down start at zero is ignored
        mode = 1'b1; pulse_ss(); mode = 1'b0;
        chk("down_zero_start", int'(running), 0);

        // Up wrap at MAX_MINUTES:59:999 with clamped preset
        do_load(40, 63);
        chk("load_clamp_min", int'(minutes), MAXM);
        chk("load_clamp_sec", int'(seconds), 59);
        pulse_ss();
        n = 0;
        while (!m_ro && n < 5000) begin step(); n++; end
        chk("wrap_wait_bound", int'(n < 5000), 1);
        chk("wrap_rollover", int'(rollover), 1);
        chk_time("wrap_zero", 0);
        chk("wrap_running", int'(running), 1);
        step();
        chk("wrap_rollover_low", int'(rollover), 0);
        $display("[TB] up count wrapped");

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            start_stop = ($urandom_range(0, 15) == 0);
            lap        = ($urandom_range(0, 15) == 0);
            clear      = ($urandom_range(0, 299) == 0);
            load       = ($urandom_range(0, 99) == 0);
            mode       = 1'($urandom_range(0, 1));
            load_min   = MIN_W'($urandom_range(0, 3));
            load_sec   = 6'($urandom_range(0, 63));
            if (load && $urandom_range(0, 1) == 0) begin
                load_min = '0; load_sec = 6'($urandom_range(0, 1));
            end
            step();
        end
        start_stop = 0; lap = 0; clear = 0; load = 0; mode = 0;
        $display("[TB] random phase done");

        // Asynchronous reset between edges while running
        do_clear();
        pulse_ss();
        steps(30);
        lap = 1'b1; step(); lap = 1'b0;
        steps(5);
        #3 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        model_reset();
        step();
        reset = 1'b0;
        steps(3);
        $display("[TB] async reset mid-run");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_timer_core.md
# stopwatch_timer_core

Parametrised successor to the team's single-mode stopwatch FSM. It is a min:sec:ms stopwatch/timer core with several additions:
- an internal millisecond prescaler, so it runs from any system clock;
- edge-detected start/stop and lap buttons;
- an up-count (stopwatch) mode and a down-count (timer) mode with load and expiry;
- lap capture and rollover/expiry flags.

It sits between the debounced button synchroniser and the display/BCD formatter.

## Interface
- CLK_PER_MS, default 1: clk cycles per millisecond tick (≥1).
- MIN_W, default 6: width of the minutes field.
- MAX_MINUTES, default 59: highest minutes value (must be < 2^MIN_W).
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start_stop  input  1  level button, synchronised; internally rising-edge detected.
- lap  input  1  level button, synchronised; internally rising-edge detected.
- clear  input  1  level, synchronous clear.
- load  input  1  level, synchronous preset (accepted only when not RUNNING).
- mode  input  1  0 = count up, 1 = count down; latched on entry to RUNNING from IDLE.
- load_min  input  MIN_W  preset minutes.
- load_sec  input  6  preset seconds.
- minutes  output  MIN_W  current minutes.
- seconds  output  6  current seconds, 0..59.
- milliseconds  output  10  current ms, 0..999.
- lap_min / lap_sec / lap_ms  output  MIN_W / 6 / 10  last captured lap time.
- lap_valid  output  1  one-cycle pulse on lap capture.
- running  output  1  high while in RUNNING.
- expired  output  1  high while in EXPIRED.
- rollover  output  1  one-cycle pulse on up-count wrap.

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Edge detection: `ss_edge = start_stop & ~start_stop_q`; `lap_edge` is formed the same way. The `_q` registers reset to 0.
- Per-cycle priority: reset > clear > load > ss_edge > tick. A lap capture does not block a tick.
- clear, in any state:
  - time goes to 0:00:000 and the prescaler goes to 0;
  - state goes to IDLE; expired goes to 0;
  - lap registers are kept.
- load, in IDLE, PAUSED or EXPIRED:
  - minutes = min(load_min, MAX_MINUTES), seconds = min(load_sec, 59), ms = 0;
  - prescaler goes to 0; state goes to IDLE.
  - load is ignored in RUNNING.
- Transitions on ss_edge:
  - IDLE → RUNNING, and the mode latch (mode_q) is loaded from mode.
  - PAUSED → RUNNING, with mode_q unchanged.
  - RUNNING → PAUSED.
  - In EXPIRED, ss_edge is ignored.
  - If mode_q or mode (whichever applies) is down and the time is 0:00:000, ss_edge from IDLE/PAUSED is ignored.
- Prescaler:
  - advances only in RUNNING;
  - tick = (presc == CLK_PER_MS-1), after which presc wraps to 0;
  - it holds its value in PAUSED.
- Up count, per tick:
  - ms+1; 999 wraps to 0 and carries into seconds;
  - 59 wraps to 0 and carries into minutes;
  - at MAX_MINUTES:59:999 the next tick gives 0:00:000, pulses rollover, and the stopwatch keeps RUNNING.
- Down count, per tick:
  - ms−1; 0 borrows from seconds, with ms set to 999;
  - seconds 0 borrows from minutes, with seconds set to 59;
  - the tick that produces 0:00:000 also moves the state to EXPIRED (running=0, expired=1). The count never goes below zero.
- Lap: lap_edge in RUNNING copies the pre-tick time of that cycle into the lap registers and pulses lap_valid. lap_edge is ignored in all other states.

## Timing
- Reset values: all time and lap outputs 0; lap_valid, running, expired and rollover all 0; state IDLE; mode_q 0; presc 0.
- All outputs are registered.
- The state changes on the clk edge that ends the cycle in which the edge or level was sampled.
- Start timing: if ss_edge is sampled in cycle N, running=1 from edge N+1, and the first ms update is at edge N+1+CLK_PER_MS.
- Stop timing: ss_edge in RUNNING suppresses that cycle's tick. Time is frozen from edge N+1.
- Pulse widths: lap_valid and rollover are each one cycle wide, asserted at the same edge as the capture or wrap.
- Holding a button: start_stop or lap held high for many cycles produces exactly one event.
- Reset mid-count: immediate asynchronous return to reset values, including lap registers.

## Test plan
- Up count, CLK_PER_MS=4: reset, then one start_stop pulse.
  - running=1 one edge after the pulse; ms=1 four edges later.
  - After 4000 further cycles: 0:01:001.
- Pause/resume: start; pause at 0:00:010; wait 50 cycles; resume.
  - Time holds at 0:00:010 while paused, and counting continues from there after resume (presc retained).
- Down count, CLK_PER_MS=1: load 0:02 in IDLE, then start with mode=1.
  - After 2000 ticks: 0:00:000, expired=1, running=0.
  - A further start_stop pulse has no effect.
  - clear returns to IDLE with expired=0.
- Up-count wrap, MAX_MINUTES=1: preset 1:59 and start.
  - After 1000 ticks: 0:00:000, rollover pulses once, running stays 1.
- Lap and priority:
  - lap at 0:00:500 → lap regs 0:00:500, lap_valid high for exactly 1 cycle, main count continues.
  - clear and start_stop in the same cycle → IDLE at 0:00:000.
  - load while RUNNING → ignored.
- Asynchronous reset asserted mid-RUNNING, between clk edges: all outputs go to 0 immediately.
